// File: rtl/p1_pkg.sv
// Constants shared by the serializer and the receive-side deserializer.
// IDLE_COM is the pattern the receive side uses to find frame alignment.
package p1_pkg;

  localparam int unsigned SER_WIDTH = 8;
  localparam logic [7:0]  IDLE_COM  = 8'hBC;

endpackage

// File: rtl/serializer_8b.sv
// Parallel-to-serial stage in the 8f domain: sends one word per frame, MSB first.
// Frames with no word offered carry IDLE_WORD. A bit counter sets the frame timing.
module serializer_8b
  import p1_pkg::*;
#(
  parameter int unsigned      WIDTH     = SER_WIDTH,
  parameter logic [WIDTH-1:0] IDLE_WORD = WIDTH'(IDLE_COM)
) (
  input  logic             clk8f,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             data_out,
  output logic             frame_start,
  output logic             active_out
);

  localparam int unsigned      CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] word;

  // The load slot is decoded from registered state only, so valid_in has no path to ready_out.
  always_comb begin
    ready_out = (bit_cnt == LAST);
    word      = valid_in ? data_in : IDLE_WORD;
  end

  always_ff @(posedge clk8f or negedge reset) begin
    if (!reset) begin
      bit_cnt     <= LAST;
      shreg       <= '0;
      data_out    <= 1'b0;
      frame_start <= 1'b0;
      active_out  <= 1'b0;
    end else if (ready_out) begin
      data_out    <= word[WIDTH-1];
      shreg       <= {word[WIDTH-2:0], 1'b0};
      bit_cnt     <= '0;
      frame_start <= 1'b1;
      active_out  <= valid_in;
    end else begin
      data_out    <= shreg[WIDTH-1];
      shreg       <= {shreg[WIDTH-2:0], 1'b0};
      bit_cnt     <= bit_cnt + CNT_W'(1);
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serializer_8b.sv
// Scoreboard bench for serializer_8b: default 8-bit instance plus a 10-bit instance.
// The models push the expected bits of each frame on load edges; the checkers pop them on the falling edge.
module tb_serializer_8b;

  typedef struct packed {
    logic d;
    logic fs;
    logic act;
  } exp_t;

  logic clk8f = 1'b0;
  logic reset = 1'b1;

  logic [7:0] data8  = '0;
  logic       valid8 = 1'b0;
  logic       rdy8, dout8, fs8, act8;

  logic [9:0] data10  = '0;
  logic       valid10 = 1'b0;
  logic       rdy10, dout10, fs10, act10;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  exp_t        q8[$];
  exp_t        q10[$];
  int unsigned m8 = 7, m10 = 9;
  bit          run8 = 1'b0, run10 = 1'b0;
  int unsigned acc8 = 0, acc10 = 0;
  logic [7:0]  w8;
  logic [9:0]  w10;

  always #5 clk8f = ~clk8f;

  serializer_8b dut8 (
    .clk8f       (clk8f),
    .reset       (reset),
    .data_in     (data8),
    .valid_in    (valid8),
    .ready_out   (rdy8),
    .data_out    (dout8),
    .frame_start (fs8),
    .active_out  (act8)
  );

  serializer_8b #(.WIDTH(10), .IDLE_WORD(10'h17C)) dut10 (
    .clk8f       (clk8f),
    .reset       (reset),
    .data_in     (data10),
    .valid_in    (valid10),
    .ready_out   (rdy10),
    .data_out    (dout10),
    .frame_start (fs10),
    .active_out  (act10)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk8f or negedge reset) begin
    if (!reset) begin
      q8.delete();
      m8   = 7;
      run8 = 1'b0;
    end else begin
      run8 = 1'b1;
      if (m8 == 7) begin
        w8 = valid8 ? data8 : 8'hBC;
        if (valid8) acc8++;
        for (int i = 7; i >= 0; i--) q8.push_back('{d: w8[i], fs: (i == 7), act: valid8});
        m8 = 0;
      end else begin
        m8++;
      end
    end
  end

  always @(posedge clk8f or negedge reset) begin
    if (!reset) begin
      q10.delete();
      m10   = 9;
      run10 = 1'b0;
    end else begin
      run10 = 1'b1;
      if (m10 == 9) begin
        w10 = valid10 ? data10 : 10'h17C;
        if (valid10) acc10++;
        for (int i = 9; i >= 0; i--) q10.push_back('{d: w10[i], fs: (i == 9), act: valid10});
        m10 = 0;
      end else begin
        m10++;
      end
    end
  end

  always @(negedge clk8f) begin
    exp_t e;
    if (!reset) begin
      check("rst_dout8", 32'(dout8), 32'd0);
      check("rst_fs8", 32'(fs8), 32'd0);
      check("rst_act8", 32'(act8), 32'd0);
      check("rst_rdy8", 32'(rdy8), 32'd1);
      check("rst_dout10", 32'(dout10), 32'd0);
      check("rst_rdy10", 32'(rdy10), 32'd1);
    end else begin
      if (run8) begin
        check("rdy8", 32'(rdy8), 32'(m8 == 7));
        if (q8.size() == 0) check("q8_underflow", 32'(q8.size()), 32'd1);
        else begin
          e = q8.pop_front();
          check("dout8", 32'(dout8), 32'(e.d));
          check("fs8", 32'(fs8), 32'(e.fs));
          check("act8", 32'(act8), 32'(e.act));
        end
      end
      if (run10) begin
        check("rdy10", 32'(rdy10), 32'(m10 == 9));
        if (q10.size() == 0) check("q10_underflow", 32'(q10.size()), 32'd1);
        else begin
          e = q10.pop_front();
          check("dout10", 32'(dout10), 32'(e.d));
          check("fs10", 32'(fs10), 32'(e.fs));
          check("act10", 32'(act10), 32'(e.act));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk8f);
    #2;
  endtask

  task automatic send8(input logic [7:0] w);
    int unsigned n;
    n      = acc8;
    data8  = w;
    valid8 = 1'b1;
    for (int k = 0; k < 40 && acc8 == n; k++) tick();
    if (acc8 == n) check("send8_timeout", acc8, n + 1);
    valid8 = 1'b0;
    data8  = $urandom_range(0, 255);
  endtask

  task automatic send10(input logic [9:0] w);
    int unsigned n;
    n       = acc10;
    data10  = w;
    valid10 = 1'b1;
    for (int k = 0; k < 40 && acc10 == n; k++) tick();
    if (acc10 == n) check("send10_timeout", acc10, n + 1);
    valid10 = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (20) tick();

    send8(8'hA5);
    repeat (16) tick();

    send8(8'h01);
    send8(8'h80);
    repeat (16) tick();

    for (int k = 0; k < 20 && m8 != 3; k++) tick();
    send8(8'h3C);
    repeat (12) tick();

    send8(8'hA5);
    for (int k = 0; k < 20 && m8 != 4; k++) tick();
    #1 reset = 1'b0;
    #1;
    check("async_dout8", 32'(dout8), 32'd0);
    check("async_act8", 32'(act8), 32'd0);
    check("async_rdy8", 32'(rdy8), 32'd1);
    repeat (2) tick();
    reset = 1'b1;
    repeat (16) tick();

    send10(10'h2AA);
    repeat (25) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serializer_8b.md
Name: serializer_8b

Overview:
- Parallel-to-serial stage directly downstream of the clock generator, running in the fastest (8f) domain.
- Takes one WIDTH-bit word per frame from the upstream stage using a valid/ready handshake and shifts it out MSB-first, one bit per clk8f cycle.
- Any frame slot with no word offered carries the idle/COM pattern IDLE_WORD.
- Frame timing comes from an internal bit counter, not from the divided clocks, so the block has a single clock.

Parameters:
WIDTH, 8, word and frame length in bits (must be >= 2)
IDLE_WORD, 8'hBC, pattern transmitted in frame slots with no valid data (WIDTH bits wide)

Ports:
clk8f  input  1  serial bit clock; the only clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset
data_in  input  WIDTH  parallel word from upstream
valid_in  input  1  data_in holds a word to send
ready_out  output  1  load slot; a word is accepted at the rising edge where valid_in && ready_out
data_out  output  1  serial bit stream, MSB first
frame_start  output  1  high during the cycle data_out carries bit WIDTH-1 of a frame
active_out  output  1  high for the whole frame if that frame carries accepted data, low for idle frames

Behaviour:
- Reset (reset==0) acts asynchronously and takes effect immediately:
  - data_out=0, frame_start=0, active_out=0
  - bit_cnt=WIDTH-1, shift register=0
  - ready_out is decoded from bit_cnt, so it reads 1 during reset.
- State is a bit counter bit_cnt in 0..WIDTH-1, wrapping WIDTH-1 -> 0. No other FSM.
- ready_out = (bit_cnt == WIDTH-1). It is decoded from registered state, with no combinational path from valid_in.
- Load edge: the rising edge where bit_cnt==WIDTH-1.
  - word = valid_in ? data_in : IDLE_WORD
  - data_out <= word[WIDTH-1]
  - shift register <= {word[WIDTH-2:0], 1'b0}
  - bit_cnt <= 0
  - frame_start <= 1
  - active_out <= valid_in
- Every other edge:
  - data_out <= shift[WIDTH-1]
  - shift <= shift << 1
  - bit_cnt <= bit_cnt+1
  - frame_start <= 0
  - active_out holds its value
- Latency: a word accepted at edge E0 drives its MSB on data_out after E0 and its LSB after E0+(WIDTH-1). The next load edge is E0+WIDTH.
- Back-to-back words give a gap-free stream of one word every WIDTH cycles.
- Throughput is exactly one frame per WIDTH cycles, with no backpressure beyond ready_out.
- valid_in asserted while ready_out==0 has no effect. Upstream holds data_in/valid_in until the load edge; a word dropped before then is never sent and is not an error.
- The first edge after reset release is a load edge, so the first frame starts at once (idle if valid_in==0).
- Reset mid-frame: the partially sent word is discarded with no resumption. After release, operation restarts as above.
- data_in is sampled only on load edges. Changes at other times are ignored.

Decomposition:
- Shared package p1_pkg holds:
  - IDLE_COM = 8'hBC, used as the IDLE_WORD default and shared with the receive-side deserializer for alignment
  - SER_WIDTH = 8
- No sub-module: counter plus shift register stay in one module.

Test Plan:
1. Hold reset=0 for 3 cycles, then release with valid_in=0 -> during reset data_out=0, active_out=0, ready_out=1. After release data_out repeats 1,0,1,1,1,1,0,0 with frame_start every 8th cycle and active_out=0.
2. Present data_in=8'hA5 with valid_in=1 on one load edge -> the next 8 bits are 1,0,1,0,0,1,0,1 with active_out=1 for exactly those 8 cycles. The following frame is 0xBC with active_out=0.
3. Back-to-back 8'h01 then 8'h80 -> 16 contiguous bits 00000001 10000000, active_out=1 throughout, frame_start pulses exactly 8 cycles apart.
4. Assert valid_in with 8'h3C at bit_cnt=3 and hold it -> nothing changes until the load edge. 0x3C is then sent starting at the first frame_start after the load.
5. Assert reset=0 at bit 4 of frame 0xA5 -> data_out and active_out go to 0 immediately, without a clock edge. After release the next frame is 0xBC and no leftover A5 bits appear.
6. WIDTH=10, IDLE_WORD=10'h17C, word 10'h2AA -> 10-bit frames MSB-first (1010101010), ready_out high every 10th cycle.
